memwr_rmw: RTL and testbench

MEMWR_RMW -- requirements
Module: memwr_rmw

---
 rtl/memwr_rmw.sv | 259 +++++++++++++++++++++++++
 tb/tb_memwr_rmw.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memwr_rmw.sv
// -----------------------------------------------------------------------------
// memwr_rmw -- store unit with read-modify-write for sub-word stores
//
// Accepts one store request at a time. Word stores go straight to a single
// full-word write. Half and byte stores first read the containing word, merge
// the new lane(s) into it, and write the merged word back. A misaligned or
// reserved-type request finishes with an error pulse and no memory access.
//
// Optional feature (macro MEMWR_BYPASS_EN): a last-word register holds the
// most recently written word. A half/byte store that hits that word is merged
// onto the register contents without a memory read (1-cycle latency).
// The default build (macro undefined) has no such register.
//
// Ports
//   clk        in   1     sole clock, rising edge
//   reset      in   1     asynchronous, active-high reset
//   req_valid  in   1     store request present
//   req_ready  out  1     block can accept a request (IDLE and not in reset)
//   req_addr   in   AW    byte address of the store
//   req_data   in   32    register value; lane data taken from its low bits
//   req_type   in   2     00 word, 01 half, 10 byte, 11 reserved
//   done       out  1     one-cycle completion pulse
//   err        out  1     error flag, valid only with done
//   mem_addr   out  AW-2  word address to data memory
//   mem_rd     out  1     read strobe; mem_rdata valid the following cycle
//   mem_rdata  in   32    read data from memory
//   mem_we     out  1     full-word write strobe
//   mem_wdata  out  32    merged write word
// -----------------------------------------------------------------------------
module memwr_rmw #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_data,
  input  logic [1:0]    req_type,
  output logic          done,
  output logic          err,
  output logic [AW-3:0] mem_addr,
  output logic          mem_rd,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [31:0]   mem_wdata
);

  // FSM state encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  // Store type encoding
  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_BYTE = 2'b10;

  // Merge the low bits of data into base at the lane selected by type/lane.
  // Lane 0 is bits 7:0; a half goes to 15:0 or 31:16 depending on lane[1].
  function automatic logic [31:0] merge_lane(
    input logic [31:0] base,
    input logic [31:0] data,
    input logic [1:0]  typ,
    input logic [1:0]  lane
  );
    logic [31:0] r;
    r = base;
    case (typ)
      TYPE_WORD: r = data;
      TYPE_HALF: begin
        if (lane[1]) begin
          r[31:16] = data[15:0];
        end else begin
          r[15:0] = data[15:0];
        end
      end
      TYPE_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          2'd3:    r[31:24] = data[7:0];
          default: r = base;
        endcase
      end
      default: r = base;
    endcase
    return r;
  endfunction

  // A request is rejected for the reserved type or a misaligned half/word.
  function automatic logic is_bad_req(
    input logic [1:0] typ,
    input logic [1:0] lane
  );
    logic bad;
    case (typ)
      TYPE_WORD: bad = (lane != 2'b00);
      TYPE_HALF: bad = lane[0];
      TYPE_BYTE: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Registered state and latched request
  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    type_q, type_d;
  logic [31:0]   buf_q, buf_d;

  // Registered strobes, computed from the next state so each is a clean flop
  logic          mem_rd_q, mem_rd_d;
  logic          mem_we_q, mem_we_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          hs_s;
  logic          hit_s;
  logic [31:0]   byp_base_s;

  assign req_ready = (state_q == IDLE) && !reset;
  assign hs_s      = req_valid && req_ready;

  assign mem_addr  = addr_q[AW-1:2];
  assign mem_wdata = buf_q;
  assign mem_rd    = mem_rd_q;
  assign mem_we    = mem_we_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef MEMWR_BYPASS_EN
  // Last-word register: copy of the word most recently written to memory.
  // This block is the only memory writer, so the copy never goes stale.
  logic [AW-3:0] lw_addr_q, lw_addr_d;
  logic [31:0]   lw_data_q, lw_data_d;
  logic          lw_valid_q, lw_valid_d;

  assign hit_s      = lw_valid_q && (lw_addr_q == req_addr[AW-1:2]);
  assign byp_base_s = lw_data_q;

  // Load the last-word register with the word about to be written
  always_comb begin
    lw_addr_d  = lw_addr_q;
    lw_data_d  = lw_data_q;
    lw_valid_d = lw_valid_q;
    if (state_d == WRITE) begin
      lw_addr_d  = addr_d[AW-1:2];
      lw_data_d  = buf_d;
      lw_valid_d = 1'b1;
    end else begin
      lw_valid_d = lw_valid_q;
    end
  end

  // Last-word register flops, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lw_addr_q  <= '0;
      lw_data_q  <= 32'h0000_0000;
      lw_valid_q <= 1'b0;
    end else begin
      lw_addr_q  <= lw_addr_d;
      lw_data_q  <= lw_data_d;
      lw_valid_q <= lw_valid_d;
    end
  end
`else
  assign hit_s      = 1'b0;
  assign byp_base_s = 32'h0000_0000;
`endif

  // Next-state, request latch and merge-buffer logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    type_d  = type_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          addr_d = req_addr;
          data_d = req_data;
          type_d = req_type;
          if (is_bad_req(req_type, req_addr[1:0])) begin
            state_d = ERR;
          end else if (req_type == TYPE_WORD) begin
            state_d = WRITE;
            buf_d   = req_data;
          end else if (hit_s) begin
            // Bypass: the target word is already held locally
            state_d = WRITE;
            buf_d   = merge_lane(byp_base_s, req_data, req_type, req_addr[1:0]);
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Read data arrives this cycle; fold the new lane into it
        buf_d   = merge_lane(mem_rdata, data_q, type_q, addr_q[1:0]);
        state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output strobes decoded from the state being entered
  always_comb begin
    mem_rd_d = (state_d == READ);
    mem_we_d = (state_d == WRITE);
    done_d   = (state_d == WRITE) || (state_d == ERR);
    err_d    = (state_d == ERR);
  end

  // State, latch and output flops; reset drops any in-flight request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= 32'h0000_0000;
      type_q   <= 2'b00;
      buf_q    <= 32'h0000_0000;
      mem_rd_q <= 1'b0;
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      type_q   <= type_d;
      buf_q    <= buf_d;
      mem_rd_q <= mem_rd_d;
      mem_we_q <= mem_we_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_memwr_rmw.sv
// -----------------------------------------------------------------------------
// tb_memwr_rmw -- scoreboard bench for memwr_rmw
//
// A behavioural memory image predicts each store's written word, latency and
// read count; predictions are queued at the handshake and a monitor compares
// them whenever the DUT pulses done. A separate memory responds to the DUT.
// -----------------------------------------------------------------------------
module tb_memwr_rmw;

`ifdef MEMWR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_type;
  logic        done;
  logic        err;
  logic [29:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  memwr_rmw #(.AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_type  (req_type),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    int          rd;
    int          hs;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] dev_mem [256];
  logic [31:0] ref_mem [256];
  logic        lw_valid;
  logic [29:0] lw_waddr;
  int          cyc = 0;
  int          rd_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Memory seen by the DUT: one-cycle read latency, full-word writes
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= dev_mem[mem_addr[7:0]];
    else        mem_rdata <= $urandom;
    if (mem_we) dev_mem[mem_addr[7:0]] <= mem_wdata;
  end

  // Monitor: compare each completion against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rd_cnt = 0;
    end else begin
      if (mem_rd) begin
        rd_cnt++;
        if (sb_q.size() > 0) check("rd_addr", {2'b00, mem_addr}, {2'b00, sb_q[0].waddr});
      end
      if (mem_we || done) check("we_vs_done", {31'd0, mem_we}, {31'd0, done & ~err});
      if (done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("err", {31'd0, err}, {31'd0, e.err});
          check("latency", cyc - e.hs + 1, e.lat);
          check("rd_count", rd_cnt, e.rd);
          if (!e.err) begin
            check("wr_addr", {2'b00, mem_addr}, {2'b00, e.waddr});
            check("wr_data", mem_wdata, e.wdata);
          end
        end
        rd_cnt = 0;
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // Issue one store, predicting its outcome from the byte-level memory image
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    exp_t        e;
    logic [31:0] old_w;
    logic [31:0] mask;
    int          sh;
    bit          hit;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_type  = t;
    e.waddr = a[31:2];
    e.err   = (t == 2'd3) || (t == 2'd1 && a[0]) || (t == 2'd0 && a[1:0] != 2'd0);
    e.wdata = 32'h0;
    e.lat   = 1;
    e.rd    = 0;
    if (!e.err) begin
      old_w = ref_mem[e.waddr[7:0]];
      if (t == 2'd0) begin
        e.wdata = d;
      end else begin
        if (t == 2'd1) begin
          sh   = a[1] ? 16 : 0;
          mask = 32'h0000_FFFF << sh;
        end else begin
          sh   = 8 * int'(a[1:0]);
          mask = 32'h0000_00FF << sh;
        end
        e.wdata = (old_w & ~mask) | ((d << sh) & mask);
        hit = BYP && lw_valid && (lw_waddr == e.waddr);
        e.lat = hit ? 1 : 3;
        e.rd  = hit ? 0 : 1;
      end
      ref_mem[e.waddr[7:0]] = e.wdata;
      lw_valid = 1'b1;
      lw_waddr = e.waddr;
    end
    @(posedge clk);
    #1;
    e.hs = cyc;
    sb_q.push_back(e);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_type  = 2'($urandom);
  endtask

  initial begin
    logic [31:0] a;
    int          mism;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    req_type  = 2'b00;
    lw_valid  = 1'b0;
    lw_waddr  = 30'd0;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = (i * 32'h0101_0101) ^ 32'hA5C3_5A3C;
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[8'h40] = 32'h1122_3344;
    ref_mem[8'h40] = 32'h1122_3344;
    dev_mem[8'h41] = 32'h1122_3344;
    ref_mem[8'h41] = 32'h1122_3344;

    // Reset state
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_done",  {31'd0, done},      32'd0);
    check("rst_err",   {31'd0, err},       32'd0);
    check("rst_rd",    {31'd0, mem_rd},    32'd0);
    check("rst_we",    {31'd0, mem_we},    32'd0);
    check("rst_addr",  {2'b00, mem_addr},  32'd0);
    check("rst_wdata", mem_wdata,          32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed stores
    issue(32'h0000_0102, 32'h0000_00AB, 2'b10);
    issue(32'h0000_0106, 32'h0000_CAFE, 2'b01);
    issue(32'h0000_0103, 32'h1234_5678, 2'b01);
    issue(32'h0000_0100, 32'hDEAD_BEEF, 2'b00);
    issue(32'h0000_0100, 32'h0000_0011, 2'b10);
    issue(32'h0000_0101, 32'h0000_0022, 2'b10);
    issue(32'h0000_0104, 32'h0000_0000, 2'b11);
    issue(32'h0000_0106, 32'h0000_0000, 2'b00);

    // Reset while the read data is due: request dropped, nothing written
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_010A;
    req_data  = 32'h0000_0055;
    req_type  = 2'b10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_we",    {31'd0, mem_we},    32'd0);
    check("mid_rst_done",  {31'd0, done},      32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_wdata", mem_wdata,          32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    lw_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    check("no_we_after_rst", {31'd0, mem_we},    32'd0);

    // Randomized stores, biased toward a few words so lanes collide
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1023));
      else                           a = 32'h0000_0100 + 32'($urandom_range(0, 15));
      issue(a, $urandom, 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Drain outstanding completions with a bounded wait
    for (int g = 0; g < 20 && sb_q.size() > 0; g++) @(negedge clk);
    check("drain_pending", sb_q.size(), 32'd0);
    @(negedge clk);

    mism = 0;
    for (int i = 0; i < 256; i++) if (dev_mem[i] !== ref_mem[i]) mism++;
    check("mem_image", mism, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
